// File: rtl/snespad_multi.sv
// snespad_multi -- SNES-protocol reader for NUM_PADS controllers that share one
// latch/clock pair. Each pad has its own serial data pin. Bits are captured into
// shadow registers and published atomically on a one-cycle valid strobe.
//
// Optional feature macro: SNESPAD_EDGE_EN (adds the `pressed` rising-edge port).
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   new_frame      in   start request, honoured only while idle
//   pad_clock_pin  out  shared pad clock (idle high)
//   pad_latch_pin  out  shared pad latch (idle low)
//   pad_data_pin   in   per-pad serial data, active low
//   buttons        out  pad p bit k at index p*NUM_BITS+k, active high
//   valid          out  one-cycle strobe when buttons updates
//   busy           out  high from frame start through the valid cycle
//   pressed        out  new & ~old buttons at each publish (SNESPAD_EDGE_EN only)
module snespad_multi #(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 16,
    parameter int DIV         = 1000,
    parameter int LATCH_TICKS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         new_frame,
    output logic                         pad_clock_pin,
    output logic                         pad_latch_pin,
    input  logic [NUM_PADS-1:0]          pad_data_pin,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic                         valid,
    output logic                         busy
`ifdef SNESPAD_EDGE_EN
    ,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed
`endif
);

    localparam int W   = NUM_PADS * NUM_BITS;
    localparam int PW  = $clog2(DIV);
    localparam int LTW = $clog2(LATCH_TICKS + 1);
    localparam int BW  = $clog2(NUM_BITS + 1);

    localparam logic [PW-1:0]  PHASE_LAST = PW'(DIV - 1);
    localparam logic [LTW-1:0] LT_LAST    = LTW'(LATCH_TICKS - 1);
    localparam logic [BW-1:0]  BIT_ALL    = BW'(NUM_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETTLE = 3'd2,
        S_LOW    = 3'd3,
        S_HIGH   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [LTW-1:0] lt_q,    lt_d;
    logic [BW-1:0]  bit_q,   bit_d;
    logic           sample_s;
    logic           phase_last_s;

    logic [W-1:0]   shadow_q, shadow_d;
    logic [W-1:0]   buttons_q;
    logic           clock_q, latch_q, valid_q, busy_q;

    assign phase_last_s = (phase_q == PHASE_LAST);

    // Next-state logic: phase/latch/bit counters and the sample strobe.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        lt_d     = lt_q;
        bit_d    = bit_q;
        sample_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (new_frame) begin
                    state_d = S_LATCH;
                    phase_d = '0;
                    lt_d    = '0;
                    bit_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LATCH: begin
                if (phase_last_s) begin
                    phase_d = '0;
                    if (lt_q == LT_LAST) begin
                        state_d = S_SETTLE;
                        lt_d    = '0;
                    end else begin
                        lt_d = lt_q + LTW'(1);
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_SETTLE: begin
                // Bit 0 is already on the data pins once the latch drops.
                if (phase_last_s) begin
                    phase_d  = '0;
                    sample_s = 1'b1;
                    bit_d    = bit_q + BW'(1);
                    state_d  = S_LOW;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_LOW: begin
                if (phase_last_s) begin
                    phase_d = '0;
                    state_d = S_HIGH;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_HIGH: begin
                // Pads shifted on the rising edge; take the new bit just
                // before the next falling edge.
                if (phase_last_s) begin
                    phase_d = '0;
                    if (bit_q < BIT_ALL) begin
                        sample_s = 1'b1;
                        bit_d    = bit_q + BW'(1);
                        state_d  = S_LOW;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Shadow shift: newest sample enters at the top so bit 0 ends at index 0.
    always_comb begin
        shadow_d = shadow_q;
        if (sample_s) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                for (int k = 0; k < NUM_BITS - 1; k++) begin
                    shadow_d[p*NUM_BITS + k] = shadow_q[p*NUM_BITS + k + 1];
                end
                shadow_d[p*NUM_BITS + NUM_BITS - 1] = ~pad_data_pin[p];
            end
        end else begin
            shadow_d = shadow_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            lt_q    <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            lt_q    <= lt_d;
            bit_q   <= bit_d;
        end
    end

    // Registered outputs, decoded from the next state so pins track it glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            clock_q   <= 1'b1;
            latch_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            shadow_q  <= '0;
            buttons_q <= '0;
        end else begin
            clock_q  <= (state_d != S_LOW);
            latch_q  <= (state_d == S_LATCH);
            valid_q  <= (state_d == S_DONE);
            busy_q   <= (state_d != S_IDLE);
            shadow_q <= shadow_d;
            if (state_d == S_DONE) begin
                buttons_q <= shadow_q;
            end else begin
                buttons_q <= buttons_q;
            end
        end
    end

`ifdef SNESPAD_EDGE_EN
    logic [W-1:0] pressed_q;

    // Rising-edge flags, refreshed together with buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            pressed_q <= '0;
        end else if (state_d == S_DONE) begin
            pressed_q <= shadow_q & ~buttons_q;
        end else begin
            pressed_q <= pressed_q;
        end
    end

    assign pressed = pressed_q;
`endif

    assign pad_clock_pin = clock_q;
    assign pad_latch_pin = latch_q;
    assign buttons       = buttons_q;
    assign valid         = valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_snespad_multi.sv
module tb_snespad_multi;

    localparam int NP  = 2;
    localparam int NB  = 4;
    localparam int DV  = 2;
    localparam int LT  = 2;
    localparam int W   = NP * NB;
    localparam int LAT = (LT + 1 + 2 * NB) * DV;

    logic          clk = 1'b0;
    logic          rst;
    logic          new_frame;
    logic          pad_clock_pin;
    logic          pad_latch_pin;
    logic [NP-1:0] pad_data_pin;
    logic [W-1:0]  buttons;
    logic          valid;
    logic          busy;
    logic [W-1:0]  pressed_s;

    snespad_multi #(
        .NUM_PADS(NP), .NUM_BITS(NB), .DIV(DV), .LATCH_TICKS(LT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .new_frame(new_frame),
        .pad_clock_pin(pad_clock_pin),
        .pad_latch_pin(pad_latch_pin),
        .pad_data_pin(pad_data_pin),
        .buttons(buttons),
        .valid(valid),
        .busy(busy)
`ifdef SNESPAD_EDGE_EN
        ,
        .pressed(pressed_s)
`endif
    );

`ifndef SNESPAD_EDGE_EN
    assign pressed_s = '0;
`endif

    always #5 clk = ~clk;

    // ---------------- pad model: parallel-load on latch, shift on clock rise
    logic [NB-1:0] words [NP];   // raw pin levels per bit (active low)
    logic [NB-1:0] shreg [NP];

    always @(posedge pad_latch_pin or posedge pad_clock_pin) begin
        for (int p = 0; p < NP; p++) begin
            if (pad_latch_pin) shreg[p] = words[p];
            else               shreg[p] = {1'b1, shreg[p][NB-1:1]};
        end
    end

    always_comb begin
        pad_data_pin = '1;
        for (int p = 0; p < NP; p++) pad_data_pin[p] = shreg[p][0];
    end

    // ---------------- scoreboard
    typedef struct {
        logic [W-1:0] btn;
        logic [W-1:0] prs;
    } exp_t;
    exp_t         sb[$];
    logic [W-1:0] prev_btn = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor
    int   cyc = 0;
    int   rise_cyc = 0;
    int   falls = 0;
    logic latch_prev = 1'b0;
    logic clk_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pad_latch_pin === 1'b1 && latch_prev !== 1'b1) begin
            rise_cyc = cyc;
            falls    = 0;
        end
        if (clk_prev === 1'b1 && pad_clock_pin === 1'b0) falls++;
        latch_prev = pad_latch_pin;
        clk_prev   = pad_clock_pin;
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("buttons", 64'(buttons), 64'(e.btn));
`ifdef SNESPAD_EDGE_EN
                check("pressed", 64'(pressed_s), 64'(e.prs));
`endif
                check("latency", 64'(cyc - rise_cyc), 64'(LAT));
                check("clock_falls", 64'(falls), 64'(NB));
                check("busy_in_valid", 64'(busy), 64'd1);
            end
        end
    end

    // ---------------- stimulus
    task automatic do_frame(input bit mid_pulse, input bit valid_pulse);
        exp_t e;
        int   n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_start", 64'(busy), 64'd0);
        for (int p = 0; p < NP; p++) e.btn[p*NB +: NB] = ~words[p];
        e.prs    = e.btn & ~prev_btn;
        prev_btn = e.btn;
        sb.push_back(e);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("latch_after_start", 64'(pad_latch_pin), 64'd1);
        if (mid_pulse) begin
            repeat ($urandom_range(2, 15)) @(negedge clk);
            new_frame = 1'b1;
            @(negedge clk);
            new_frame = 1'b0;
        end
        n = 0;
        while (valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (valid !== 1'b1) begin
            check("valid_timeout", 64'd0, 64'd1);
        end else if (valid_pulse) begin
            new_frame = 1'b1;
            @(negedge clk);
            new_frame = 1'b0;
            check("no_restart_from_valid_cycle", 64'(busy), 64'd0);
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        new_frame = 1'b0;
        for (int p = 0; p < NP; p++) words[p] = '1;

        repeat (3) @(negedge clk);
        check("rst_clock", 64'(pad_clock_pin), 64'd1);
        check("rst_latch", 64'(pad_latch_pin), 64'd0);
        check("rst_buttons", 64'(buttons), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pressed", 64'(pressed_s), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed frame with ignored restarts mid-frame and in the valid cycle.
        words[0] = 4'b1010;
        words[1] = 4'b0110;
        do_frame(1'b1, 1'b1);
        check("directed_buttons", 64'(buttons), 64'h95);

        // B held, then B+Y held.
        for (int p = 0; p < NP; p++) words[p] = 4'b1110;
        do_frame(1'b0, 1'b0);
        for (int p = 0; p < NP; p++) words[p] = 4'b1100;
        do_frame(1'b0, 1'b0);

        // Randomised frames.
        for (int f = 0; f < 20; f++) begin
            for (int p = 0; p < NP; p++) words[p] = NB'($urandom);
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset during LOW of bit 2.
        for (int p = 0; p < NP; p++) words[p] = NB'($urandom);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        begin
            int n;
            n = 0;
            while (!(falls == 3 && pad_clock_pin === 1'b0) && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("reached_low_bit2", 64'(falls == 3 && pad_clock_pin === 1'b0), 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        prev_btn = '0;
        check("abort_clock", 64'(pad_clock_pin), 64'd1);
        check("abort_latch", 64'(pad_latch_pin), 64'd0);
        check("abort_buttons", 64'(buttons), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_pressed", 64'(pressed_s), 64'd0);
        repeat (30) @(negedge clk);

        // Recovery frames.
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < NP; p++) words[p] = NB'($urandom);
            do_frame(1'b0, 1'b0);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
